// File: rtl/axis_mm_pkg.sv
// Shared state encoding and width helpers for the matrix-multiply stream controller.
package axis_mm_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

  function automatic int d_dw(input int width, input int chunk, input int cores);
    return width * chunk * cores;
  endfunction

  function automatic int w_dw(input int width, input int chunk);
    return width * chunk;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_mm_obuf.sv
// Result buffer between the BRAM read port and the result stream: data plus last, depth DEPTH.
// Flop-based storage, so a write is visible at the output one cycle later; in_rdy counts a same-cycle pop.
module axis_mm_obuf
  import axis_mm_pkg::*;
#(
  parameter int DW    = 128,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_dat,
  input  logic          in_last,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [DW-1:0] out_dat,
  output logic          out_last,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [CW-1:0] count
);

  logic [DW:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_vld             = (count != '0);
  assign pop                 = out_vld && out_rdy;
  assign in_rdy              = (count != CW'(DEPTH)) || out_rdy;
  assign push                = in_vld && in_rdy;
  assign {out_last, out_dat} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_last, in_dat};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_mm_stream_ctrl.sv
// Loads weight/input streams into the core BRAMs, kicks the core, then drains results to AXI-Stream.
// Load writes are zero-latency; first result beat RD_LATENCY+1 cycles into DRAIN; full m_axis backpressure.
module axis_mm_stream_ctrl
  import axis_mm_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES  = 2,
  parameter int W_WORDS    = 6,
  parameter int I_WORDS    = 6,
  parameter int O_WORDS    = 9,
  parameter int RD_LATENCY = 1,
  localparam int D_DW      = d_dw(WIDTH, CHUNK_SIZE, NUM_CORES),
  localparam int W_DW      = w_dw(WIDTH, CHUNK_SIZE),
  localparam int WAW       = addr_w(W_WORDS),
  localparam int IAW       = addr_w(I_WORDS),
  localparam int OAW       = addr_w(O_WORDS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              cfg_reuse_w,
  input  logic [W_DW-1:0]   s_axis_w_tdata,
  input  logic              s_axis_w_tvalid,
  input  logic              s_axis_w_tlast,
  output logic              s_axis_w_tready,
  input  logic [D_DW-1:0]   s_axis_i_tdata,
  input  logic              s_axis_i_tvalid,
  input  logic              s_axis_i_tlast,
  output logic              s_axis_i_tready,
  output logic [D_DW-1:0]   m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              wb_ena,
  output logic [W_DW/8-1:0] wb_wea,
  output logic [WAW-1:0]    wb_addra,
  output logic [W_DW-1:0]   wb_dina,
  output logic              in_ena,
  output logic [D_DW/8-1:0] in_wea,
  output logic [IAW-1:0]    in_addra,
  output logic [D_DW-1:0]   in_dina,
  output logic              top_start,
  input  logic              top_done,
  output logic              out_enb,
  output logic [OAW-1:0]    out_addrb,
  input  logic [D_DW-1:0]   out_doutb,
  output logic              busy,
  output logic              frame_done,
  output logic              err_tlast
);

  localparam int OB_DEPTH = RD_LATENCY + 1;
  localparam int OB_CW    = $clog2(OB_DEPTH + 1);
  localparam int WCW      = addr_w(W_WORDS + 1);
  localparam int ICW      = addr_w(I_WORDS + 1);
  localparam int OCW      = addr_w(O_WORDS + 1);

  state_t                state;
  state_t                state_nxt;
  logic [WCW-1:0]        w_cnt;
  logic [ICW-1:0]        i_cnt;
  logic [OCW-1:0]        rd_cnt;
  logic                  skip_w;
  logic                  w_loaded;
  logic                  w_hs;
  logic                  i_hs;
  logic                  w_done_nxt;
  logic                  i_done_nxt;
  logic                  load_done;
  logic                  issue;
  logic                  credit_ok;
  logic                  pop;
  logic                  last_hs;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [RD_LATENCY-1:0] last_pipe;
  logic                  ob_in_rdy;
  logic [OB_CW-1:0]      ob_count;

  // ---------------- load side ----------------
  assign s_axis_w_tready = (state == LOAD) && !skip_w && (w_cnt < WCW'(W_WORDS));
  assign s_axis_i_tready = (state == LOAD) && (i_cnt < ICW'(I_WORDS));
  assign w_hs            = s_axis_w_tready && s_axis_w_tvalid;
  assign i_hs            = s_axis_i_tready && s_axis_i_tvalid;

  assign wb_ena   = w_hs;
  assign wb_wea   = {(W_DW/8){w_hs}};
  assign wb_addra = w_hs ? w_cnt[WAW-1:0] : '0;
  assign wb_dina  = w_hs ? s_axis_w_tdata : '0;
  assign in_ena   = i_hs;
  assign in_wea   = {(D_DW/8){i_hs}};
  assign in_addra = i_hs ? i_cnt[IAW-1:0] : '0;
  assign in_dina  = i_hs ? s_axis_i_tdata : '0;

  // Completion includes this cycle's handshake so START lands one cycle after the last beat.
  assign w_done_nxt = skip_w || (w_cnt == WCW'(W_WORDS))
                    || (w_hs && (w_cnt == WCW'(W_WORDS - 1)));
  assign i_done_nxt = (i_cnt == ICW'(I_WORDS)) || (i_hs && (i_cnt == ICW'(I_WORDS - 1)));
  assign load_done  = w_done_nxt && i_done_nxt;

  // ---------------- drain side ----------------
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign credit_ok = (int'(ob_count) + $countones(rd_pipe) - int'(pop)) < OB_DEPTH;
  assign issue     = (state == DRAIN) && (rd_cnt < OCW'(O_WORDS)) && credit_ok && ob_in_rdy;
  assign out_enb   = issue;
  assign out_addrb = issue ? rd_cnt[OAW-1:0] : '0;
  assign last_hs   = (state == DRAIN) && pop && m_axis_tlast;
  assign busy      = (state != IDLE);

  axis_mm_obuf #(
    .DW    (D_DW),
    .DEPTH (OB_DEPTH)
  ) u_obuf (
    .clk      (aclk),
    .rst_n    (aresetn),
    .in_dat   (out_doutb),
    .in_last  (last_pipe[RD_LATENCY-1]),
    .in_vld   (rd_pipe[RD_LATENCY-1]),
    .in_rdy   (ob_in_rdy),
    .out_dat  (m_axis_tdata),
    .out_last (m_axis_tlast),
    .out_vld  (m_axis_tvalid),
    .out_rdy  (m_axis_tready),
    .count    (ob_count)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    top_start = 1'b0;
    unique case (state)
      IDLE:    if (enable) state_nxt = LOAD;
      LOAD:    if (load_done) state_nxt = START;
      START: begin
        top_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (top_done) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- counters and flags ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_cnt      <= '0;
      i_cnt      <= '0;
      rd_cnt     <= '0;
      skip_w     <= 1'b0;
      w_loaded   <= 1'b0;
      err_tlast  <= 1'b0;
      frame_done <= 1'b0;
      rd_pipe    <= '0;
      last_pipe  <= '0;
    end else begin
      frame_done <= last_hs;
      rd_pipe    <= (rd_pipe << 1) | RD_LATENCY'(issue);
      last_pipe  <= (last_pipe << 1) | RD_LATENCY'(issue && (rd_cnt == OCW'(O_WORDS - 1)));
      if (state == IDLE && enable) begin
        skip_w <= cfg_reuse_w && w_loaded;
        w_cnt  <= '0;
        i_cnt  <= '0;
        rd_cnt <= '0;
      end
      if (w_hs) w_cnt <= w_cnt + WCW'(1);
      if (i_hs) i_cnt <= i_cnt + ICW'(1);
      if (issue) rd_cnt <= rd_cnt + OCW'(1);
      if (state == LOAD && load_done && !skip_w) w_loaded <= 1'b1;
      // Framing comes from the parameters; tlast is only checked against them.
      if (w_hs && (s_axis_w_tlast != (w_cnt == WCW'(W_WORDS - 1)))) err_tlast <= 1'b1;
      if (i_hs && (s_axis_i_tlast != (i_cnt == ICW'(I_WORDS - 1)))) err_tlast <= 1'b1;
      if (last_hs) begin
        w_cnt  <= '0;
        i_cnt  <= '0;
        rd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axis_mm_stream_ctrl.sv
// Directed bench for axis_mm_stream_ctrl: load, reuse, drain with backpressure, framing error, reset mid-drain.
module tb_axis_mm_stream_ctrl;

  localparam int D_DW = 128;
  localparam int W_DW = 64;

  logic              aclk;
  logic              aresetn;
  logic              enable;
  logic              cfg_reuse_w;
  logic [W_DW-1:0]   s_axis_w_tdata;
  logic              s_axis_w_tvalid;
  logic              s_axis_w_tlast;
  logic              s_axis_w_tready;
  logic [D_DW-1:0]   s_axis_i_tdata;
  logic              s_axis_i_tvalid;
  logic              s_axis_i_tlast;
  logic              s_axis_i_tready;
  logic [D_DW-1:0]   m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic              wb_ena;
  logic [W_DW/8-1:0] wb_wea;
  logic [2:0]        wb_addra;
  logic [W_DW-1:0]   wb_dina;
  logic              in_ena;
  logic [D_DW/8-1:0] in_wea;
  logic [2:0]        in_addra;
  logic [D_DW-1:0]   in_dina;
  logic              top_start;
  logic              top_done;
  logic              out_enb;
  logic [3:0]        out_addrb;
  logic [D_DW-1:0]   out_doutb;
  logic              busy;
  logic              frame_done;
  logic              err_tlast;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_err = 0;

  axis_mm_stream_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .cfg_reuse_w(cfg_reuse_w),
    .s_axis_w_tdata(s_axis_w_tdata), .s_axis_w_tvalid(s_axis_w_tvalid),
    .s_axis_w_tlast(s_axis_w_tlast), .s_axis_w_tready(s_axis_w_tready),
    .s_axis_i_tdata(s_axis_i_tdata), .s_axis_i_tvalid(s_axis_i_tvalid),
    .s_axis_i_tlast(s_axis_i_tlast), .s_axis_i_tready(s_axis_i_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .in_ena(in_ena), .in_wea(in_wea), .in_addra(in_addra), .in_dina(in_dina),
    .top_start(top_start), .top_done(top_done),
    .out_enb(out_enb), .out_addrb(out_addrb), .out_doutb(out_doutb),
    .busy(busy), .frame_done(frame_done), .err_tlast(err_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [W_DW-1:0] wdat(input int k);
    return {4{16'hA000 + 16'(k)}};
  endfunction

  function automatic logic [D_DW-1:0] idat(input int k);
    return {8{16'hB000 + 16'(k)}};
  endfunction

  function automatic logic [D_DW-1:0] owrd(input int k);
    return {4{32'hC0DE_0000 | 32'(k)}};
  endfunction

  // Result BRAM model with one cycle read latency.
  always @(posedge aclk) begin
    if (out_enb) out_doutb <= owrd(int'(out_addrb));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input bit reuse, input bit exp_skip, input int bad_idx);
    @(negedge aclk);
    enable = 1'b1;
    cfg_reuse_w = reuse;
    @(negedge aclk);
    enable = 1'b0;
    cfg_reuse_w = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_axis_w_tvalid = 1'b1;
      s_axis_w_tdata  = wdat(k);
      s_axis_w_tlast  = (k == 5);
      s_axis_i_tvalid = 1'b1;
      s_axis_i_tdata  = idat(k);
      s_axis_i_tlast  = (bad_idx < 0) ? (k == 5) : (k == bad_idx);
      #1;
      chk("w_tready", s_axis_w_tready, !exp_skip);
      chk("wb_ena", wb_ena, !exp_skip);
      chk("wb_wea", wb_wea, exp_skip ? 8'h00 : 8'hFF);
      if (!exp_skip) begin
        chk("wb_addra", wb_addra, k);
        chk("wb_dina", wb_dina, wdat(k));
      end
      chk("in_ena", in_ena, 1);
      chk("in_wea", in_wea, 16'hFFFF);
      chk("in_addra", in_addra, k);
      chk("in_dina", in_dina, idat(k));
      chk("err_tlast", err_tlast, exp_err);
      if (s_axis_i_tlast != (k == 5)) exp_err = 1'b1;
      @(negedge aclk);
    end
    s_axis_w_tvalid = 1'b0;
    s_axis_i_tvalid = 1'b0;
    s_axis_w_tlast  = 1'b0;
    s_axis_i_tlast  = 1'b0;
    #1;
    chk("start_pulse", top_start, 1);
    chk("start_i_tready", s_axis_i_tready, 0);
    @(negedge aclk);
    #1;
    chk("start_once", top_start, 0);
    chk("wait_busy", busy, 1);
    chk("err_after_load", err_tlast, exp_err);
  endtask

  task automatic do_drain(input int delay, input bit toggle);
    int beat;
    int first;
    int last_c;
    bit hold;
    logic [D_DW-1:0] held_d;
    logic held_l;
    logic [3:0] pat;
    beat = 0; first = -1; last_c = -1; hold = 0; held_d = '0; held_l = 0;
    pat = 4'b1001;
    repeat (delay) @(negedge aclk);
    #1;
    chk("wait_no_read", out_enb, 0);
    chk("wait_no_tvalid", m_axis_tvalid, 0);
    chk("wait_no_start", top_start, 0);
    top_done = 1'b1;
    @(negedge aclk);
    top_done = 1'b0;
    for (int c = 0; c < 200 && beat < 9; c++) begin
      m_axis_tready = toggle ? pat[c % 4] : 1'b1;
      #1;
      if (hold) begin
        chk("hold_tvalid", m_axis_tvalid, 1);
        chk("hold_tdata", m_axis_tdata, held_d);
        chk("hold_tlast", m_axis_tlast, held_l);
      end
      if (m_axis_tvalid) begin
        if (first < 0) first = c;
        if (m_axis_tready) begin
          chk("beat_tdata", m_axis_tdata, owrd(beat));
          chk("beat_tlast", m_axis_tlast, (beat == 8));
          chk("beat_no_done", frame_done, 0);
          beat++;
          last_c = c;
          hold = 0;
        end else begin
          hold   = 1;
          held_d = m_axis_tdata;
          held_l = m_axis_tlast;
        end
      end
      @(negedge aclk);
    end
    chk("beat_count", beat, 9);
    chk("first_valid_lat", first, 2);
    if (!toggle) chk("throughput", last_c - first, 8);
    #1;
    chk("frame_done", frame_done, 1);
    chk("done_idle", busy, 0);
    chk("done_tvalid", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;
    @(negedge aclk);
    #1;
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; cfg_reuse_w = 1'b0;
    s_axis_w_tdata = '0; s_axis_w_tvalid = 1'b0; s_axis_w_tlast = 1'b0;
    s_axis_i_tdata = '0; s_axis_i_tvalid = 1'b0; s_axis_i_tlast = 1'b0;
    m_axis_tready = 1'b0; top_done = 1'b0; out_doutb = '0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_w_tready", s_axis_w_tready, 0);
    chk("rst_i_tready", s_axis_i_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_wb_ena", wb_ena, 0);
    chk("rst_in_ena", in_ena, 0);
    chk("rst_out_enb", out_enb, 0);
    chk("rst_start", top_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_tlast, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Reuse requested before any weights exist: weights still load.
    do_load(1, 0, -1);
    do_drain(20, 1);

    // top_done outside WAIT is ignored.
    @(negedge aclk);
    top_done = 1'b1;
    @(negedge aclk);
    top_done = 1'b0;
    #1;
    chk("idle_done_ignored", busy, 0);

    do_load(1, 1, -1);
    do_drain(3, 0);

    do_load(0, 0, 3);
    do_drain(2, 1);
    chk("err_sticky", err_tlast, 1);

    // Reset while results are buffered.
    do_load(1, 1, -1);
    repeat (3) @(negedge aclk);
    #1 top_done = 1'b1;
    @(negedge aclk);
    top_done = 1'b0;
    m_axis_tready = 1'b0;
    repeat (4) @(negedge aclk);
    #1;
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #1 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_tlast, 0);
    chk("arst_out_enb", out_enb, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_err = 1'b0;

    // w_loaded was cleared by reset, so weights reload despite reuse.
    do_load(1, 0, -1);
    do_drain(2, 0);
    chk("final_err", err_tlast, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
